// File: rtl/au_pkg.sv
// Shared definitions for the AU sequencer: op/operand-select codes, the instruction
// header layout and the FSM state encoding.
package au_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    Y_S   = 2'b00,
    Y_IMM = 2'b01,
    Y_INV = 2'b10,
    Y_RSV = 2'b11
  } ysel_e;

  // Instruction word = {last, op, ysel, rd, ra, rb}; the register fields follow the header.
  localparam int OP_W   = 2;
  localparam int YSEL_W = 2;
  localparam int HDR_W  = 1 + OP_W + YSEL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_FIX,
    S_WB,
    S_WAIT_DONE,
    S_NEXT
  } state_e;

  typedef struct packed {
    logic  last;
    op_e   op;
    ysel_e ysel;
    logic  is_long;
  } ctrl_t;

  // DIV always uses the reciprocal path; the reserved select falls back to S.
  function automatic ysel_e decode_ysel(op_e op, ysel_e ysel);
    if (op == OP_DIV) return Y_INV;
    if (ysel == Y_RSV) return Y_S;
    return ysel;
  endfunction

  // Anything that goes through the AU reciprocal unit has data-dependent latency.
  function automatic logic is_long_op(op_e op, ysel_e ysel_dec);
    return (op == OP_DIV) || (op == OP_MUL && ysel_dec == Y_INV);
  endfunction

endpackage

// File: rtl/au_sequencer_if.sv
// Start/done handshake and operand bus between the sequencer (master) and the AU (slave).
interface au_sequencer_if
  import au_pkg::*;
#(
  parameter int W = 24
);
  logic         au_start;
  op_e          au_op_sel;
  ysel_e        au_mul_y_sel;
  logic [W-1:0] au_R;
  logic [W-1:0] au_S;
  logic [W-1:0] au_Iimm;
  logic [W-1:0] au_result;
  logic         au_done;
  logic         au_busy;

  modport master (
    output au_start, au_op_sel, au_mul_y_sel, au_R, au_S, au_Iimm,
    input  au_result, au_done, au_busy
  );

  modport slave (
    input  au_start, au_op_sel, au_mul_y_sel, au_R, au_S, au_Iimm,
    output au_result, au_done, au_busy
  );
endinterface

// File: rtl/au_regfile.sv
// Operand register file: one write port, two instruction read ports, one host read port,
// plus a fixed tap on the top entry, which serves as the immediate register.
module au_regfile #(
  parameter int W    = 24,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic [RA_W-1:0] ra_addr,
  output logic [W-1:0]    ra_data,
  input  logic [RA_W-1:0] rb_addr,
  output logic [W-1:0]    rb_data,
  input  logic [RA_W-1:0] host_addr,
  output logic [W-1:0]    host_data,
  output logic [W-1:0]    imm_data
);
  localparam int NREG = 2 ** RA_W;

  logic [W-1:0] mem [NREG];

  // NOTE: every entry is a real flop with async reset so a reset leaves a known all-zero
  // file; this cannot map onto a RAM macro, which is acceptable at 16 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data   = mem[ra_addr];
  assign rb_data   = mem[rb_addr];
  assign host_data = mem[host_addr];
  assign imm_data  = mem[NREG-1];

endmodule

// File: rtl/au_sequencer.sv
// Micro-program sequencer for the AU: fetches from a synchronous ROM, latches operands,
// issues one start pulse per instruction and writes the result back to the register file.
module au_sequencer
  import au_pkg::*;
#(
  parameter int W       = 24,
  parameter int FRAC    = 14,
  parameter int RA_W    = 4,
  parameter int PC_W    = 6,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  output logic                    busy,
  output logic                    prog_done,
  output logic                    err,
  output logic [PC_W-1:0]         instr_addr,
  input  logic [HDR_W+3*RA_W-1:0] instr_data,
  input  logic                    host_we,
  input  logic [RA_W-1:0]         host_addr,
  input  logic [W-1:0]            host_wdata,
  output logic [W-1:0]            host_rdata,
  au_sequencer_if.master          au
);
  localparam int IW = HDR_W + 3 * RA_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  // The sequencer only moves words around; FRAC must still describe a legal Q format.
  if (FRAC < 0 || FRAC >= W) begin : g_bad_frac
    $error("au_sequencer: FRAC must lie in [0, W-1]");
  end

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic            err_q;
  logic [TW-1:0]   wait_cnt_q;
  ctrl_t           ctrl_q;
  logic [RA_W-1:0] rd_q;
  logic [W-1:0]    r_q, s_q, imm_q;

  // Decode of the ROM word, valid while in DECODE.
  ctrl_t           dec_ctrl;
  logic [RA_W-1:0] dec_rd, dec_ra, dec_rb;
  op_e             dec_op;
  ysel_e           dec_ysel;

  assign dec_op   = op_e'(instr_data[IW-2 -: OP_W]);
  assign dec_ysel = decode_ysel(dec_op, ysel_e'(instr_data[IW-4 -: YSEL_W]));
  assign dec_rd   = instr_data[2*RA_W +: RA_W];
  assign dec_ra   = instr_data[RA_W +: RA_W];
  assign dec_rb   = instr_data[0 +: RA_W];
  assign dec_ctrl = '{last:    instr_data[IW-1],
                      op:      dec_op,
                      ysel:    dec_ysel,
                      is_long: is_long_op(dec_op, dec_ysel)};

  // Register file: host owns the write port in IDLE, writeback owns it otherwise.
  logic         rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [W-1:0] rf_wdata, rf_ra_data, rf_rb_data, rf_imm_data;
  logic         in_idle, wb_fix, wb_long, timeout_hit, prog_end;

  assign in_idle     = (state_q == S_IDLE);
  assign wb_fix      = (state_q == S_WB);
  assign wb_long     = (state_q == S_WAIT_DONE) && au.au_done;
  assign timeout_hit = (wait_cnt_q == TW'(TIMEOUT - 1));
  assign prog_end    = ctrl_q.last || (pc_q == {PC_W{1'b1}});

  assign rf_we    = (in_idle && host_we) || wb_fix || wb_long;
  assign rf_waddr = in_idle ? host_addr  : rd_q;
  assign rf_wdata = in_idle ? host_wdata : au.au_result;

  au_regfile #(
    .W    (W),
    .RA_W (RA_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .ra_addr   (dec_ra),
    .ra_data   (rf_ra_data),
    .rb_addr   (dec_rb),
    .rb_data   (rf_rb_data),
    .host_addr (host_addr),
    .host_data (host_rdata),
    .imm_data  (rf_imm_data)
  );

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    prog_done = 1'b0;
    unique case (state_q)
      S_IDLE:     if (go) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = S_ISSUE;
      S_ISSUE:    state_d = ctrl_q.is_long ? S_WAIT_DONE : S_WAIT_FIX;
      S_WAIT_FIX: state_d = S_WB;
      S_WB:       state_d = S_NEXT;
      S_WAIT_DONE: begin
        if (au.au_done) begin
          state_d = S_NEXT;
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          prog_done = 1'b1;
        end
      end
      S_NEXT: begin
        if (prog_end) begin
          state_d   = S_IDLE;
          prog_done = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && go) begin
        pc_q  <= '0;
        err_q <= 1'b0;
      end else if (state_q == S_NEXT && !prog_end) begin
        pc_q <= pc_q + 1'b1;
      end
      if (state_q == S_WAIT_DONE && !au.au_done && timeout_hit) err_q <= 1'b1;
      if (state_q == S_ISSUE) wait_cnt_q <= '0;
      else if (state_q == S_WAIT_DONE) wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Operands and controls are captured once per instruction and held until the next DECODE,
  // so rd may alias ra/rb without a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '{last: 1'b0, op: OP_ADD, ysel: Y_S, is_long: 1'b0};
      rd_q   <= '0;
      r_q    <= '0;
      s_q    <= '0;
      imm_q  <= '0;
    end else if (state_q == S_DECODE) begin
      ctrl_q <= dec_ctrl;
      rd_q   <= dec_rd;
      r_q    <= rf_ra_data;
      s_q    <= rf_rb_data;
      imm_q  <= rf_imm_data;
    end
  end

  assign busy       = !in_idle;
  assign err        = err_q;
  assign instr_addr = pc_q;

  assign au.au_start     = (state_q == S_ISSUE);
  assign au.au_op_sel    = ctrl_q.op;
  assign au.au_mul_y_sel = ctrl_q.ysel;
  assign au.au_R         = r_q;
  assign au.au_S         = s_q;
  assign au.au_Iimm      = imm_q;

  // au_busy is observable on the bus but the sequencer relies on au_done alone.
  logic unused_au_busy;
  assign unused_au_busy = au.au_busy;

endmodule
